// File: rtl/pc_fetch.sv
//------------------------------------------------------------------------------
// Module   : pc_fetch
// Brief    : Program counter and IF/ID pipeline register with branch/flush
//            redirect, stall-deferred branches and fetch-address-error tagging.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target_addr,
    output logic        rom_inst_en,
    output logic [31:0] rom_inst_addr,
    input  logic [31:0] rom_inst,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_excp_adef
);

    logic [31:0] pc_q,          pc_d;
    logic        pend_valid_q,  pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        id_valid_q,    id_valid_d;
    logic [31:0] id_pc_q,       id_pc_d;
    logic [31:0] id_inst_q,     id_inst_d;
    logic        id_adef_q,     id_adef_d;

    logic w_misaligned;

    assign w_misaligned  = (pc_q[1:0] != 2'b00);
    assign rom_inst_addr = pc_q;
    assign rom_inst_en   = rst & ~w_misaligned;

    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        id_valid_d    = id_valid_q;
        id_pc_d       = id_pc_q;
        id_inst_d     = id_inst_q;
        id_adef_d     = id_adef_q;

        if (flush) begin
            pc_d         = new_pc;
            id_valid_d   = 1'b0;
            pend_valid_d = 1'b0;
        end else if (stall) begin
            // A branch resolved while stalled is remembered and applied later.
            if (branch_flag) begin
                pend_valid_d  = 1'b1;
                pend_target_d = branch_target_addr;
            end
        end else if (pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
            id_valid_d   = 1'b0;
        end else if (branch_flag) begin
            pc_d       = branch_target_addr;
            id_valid_d = 1'b0;
        end else begin
            pc_d       = pc_q + 32'd4;
            id_valid_d = 1'b1;
            id_pc_d    = pc_q;
            id_inst_d  = w_misaligned ? 32'd0 : rom_inst;
            id_adef_d  = w_misaligned;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
            id_valid_q    <= 1'b0;
            id_pc_q       <= 32'd0;
            id_inst_q     <= 32'd0;
            id_adef_q     <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            id_valid_q    <= id_valid_d;
            id_pc_q       <= id_pc_d;
            id_inst_q     <= id_inst_d;
            id_adef_q     <= id_adef_d;
        end
    end

    assign id_valid     = id_valid_q;
    assign id_pc        = id_pc_q;
    assign id_inst      = id_inst_q;
    assign id_excp_adef = id_adef_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
//------------------------------------------------------------------------------
// Module   : tb_pc_fetch
// Brief    : Directed self-checking bench for pc_fetch.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = 32'd0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target_addr = 32'd0;
    logic        rom_inst_en;
    logic [31:0] rom_inst_addr;
    logic [31:0] rom_inst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_excp_adef;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // ROM contents: each word is its address XOR a fixed tag.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'hdead0000;
    endfunction

    assign rom_inst = rom_word(rom_inst_addr);

    pc_fetch #(.RESET_PC(32'h1c000000)) dut (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .flush              (flush),
        .new_pc             (new_pc),
        .branch_flag        (branch_flag),
        .branch_target_addr (branch_target_addr),
        .rom_inst_en        (rom_inst_en),
        .rom_inst_addr      (rom_inst_addr),
        .rom_inst           (rom_inst),
        .id_valid           (id_valid),
        .id_pc              (id_pc),
        .id_inst            (id_inst),
        .id_excp_adef       (id_excp_adef)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        step();
        step();
        check("rst_en",    {31'd0, rom_inst_en}, 32'd0);
        check("rst_addr",  rom_inst_addr, 32'h1c000000);
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_pc",    id_pc, 32'd0);
        check("rst_inst",  id_inst, 32'd0);
        check("rst_adef",  {31'd0, id_excp_adef}, 32'd0);

        // Sequential fetch of three words
        rst = 1'b1;
        #1;
        check("rel_en", {31'd0, rom_inst_en}, 32'd1);
        step();
        check("seq0_pc",    id_pc, 32'h1c000000);
        check("seq0_inst",  id_inst, 32'hc2ad0000);
        check("seq0_valid", {31'd0, id_valid}, 32'd1);
        step();
        check("seq1_pc",   id_pc, 32'h1c000004);
        check("seq1_inst", id_inst, 32'hc2ad0004);
        step();
        check("seq2_pc",   id_pc, 32'h1c000008);
        check("seq2_inst", id_inst, 32'hc2ad0008);
        check("seq2_addr", rom_inst_addr, 32'h1c00000c);

        // Restart, then branch while pc = 1c000008
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        step();
        check("pre_br_addr", rom_inst_addr, 32'h1c000008);
        branch_flag = 1'b1;
        branch_target_addr = 32'h1c000100;
        step();
        branch_flag = 1'b0;
        check("br_valid", {31'd0, id_valid}, 32'd0);
        check("br_addr",  rom_inst_addr, 32'h1c000100);
        step();
        check("br_tgt_pc",    id_pc, 32'h1c000100);
        check("br_tgt_valid", {31'd0, id_valid}, 32'd1);
        check("br_tgt_inst",  id_inst, 32'hc2ad0100);

        // Three-cycle stall with a branch in the second cycle
        stall = 1'b1;
        step();
        check("st1_addr", rom_inst_addr, 32'h1c000104);
        check("st1_pc",   id_pc, 32'h1c000100);
        branch_flag = 1'b1;
        branch_target_addr = 32'h1c000200;
        step();
        branch_flag = 1'b0;
        check("st2_addr",  rom_inst_addr, 32'h1c000104);
        check("st2_valid", {31'd0, id_valid}, 32'd1);
        step();
        check("st3_addr", rom_inst_addr, 32'h1c000104);
        check("st3_pc",   id_pc, 32'h1c000100);
        // Pending redirect must win over a fresh branch this cycle
        stall = 1'b0;
        branch_flag = 1'b1;
        branch_target_addr = 32'h1c000300;
        step();
        branch_flag = 1'b0;
        check("pend_addr",  rom_inst_addr, 32'h1c000200);
        check("pend_valid", {31'd0, id_valid}, 32'd0);
        step();
        check("pend_tgt_pc",    id_pc, 32'h1c000200);
        check("pend_tgt_valid", {31'd0, id_valid}, 32'd1);

        // Flush beats stall and branch, and clears pending state
        flush = 1'b1;
        new_pc = 32'h1c000800;
        stall = 1'b1;
        branch_flag = 1'b1;
        branch_target_addr = 32'h1c000400;
        step();
        flush = 1'b0;
        stall = 1'b0;
        branch_flag = 1'b0;
        check("fl_addr",  rom_inst_addr, 32'h1c000800);
        check("fl_valid", {31'd0, id_valid}, 32'd0);
        step();
        check("fl_next_pc",   id_pc, 32'h1c000800);
        check("fl_next_addr", rom_inst_addr, 32'h1c000804);

        // Misaligned branch target raises ADEF
        branch_flag = 1'b1;
        branch_target_addr = 32'h1c000102;
        step();
        branch_flag = 1'b0;
        check("mis_addr", rom_inst_addr, 32'h1c000102);
        check("mis_en",   {31'd0, rom_inst_en}, 32'd0);
        step();
        check("adef_flag",  {31'd0, id_excp_adef}, 32'd1);
        check("adef_inst",  id_inst, 32'd0);
        check("adef_pc",    id_pc, 32'h1c000102);
        check("adef_valid", {31'd0, id_valid}, 32'd1);
        check("adef_addr",  rom_inst_addr, 32'h1c000106);

        // PC wraps from fffffffc to 0
        flush = 1'b1;
        new_pc = 32'hfffffffc;
        step();
        flush = 1'b0;
        check("wrap_en", {31'd0, rom_inst_en}, 32'd1);
        step();
        check("wrap_pc",   id_pc, 32'hfffffffc);
        check("wrap_addr", rom_inst_addr, 32'h00000000);
        check("wrap_adef", {31'd0, id_excp_adef}, 32'd0);
        check("wrap_inst", id_inst, 32'h2152fffc);

        // Reset during a stall with a pending branch
        stall = 1'b1;
        branch_flag = 1'b1;
        branch_target_addr = 32'h1c000500;
        step();
        rst = 1'b0;
        step();
        check("rr_addr",  rom_inst_addr, 32'h1c000000);
        check("rr_en",    {31'd0, rom_inst_en}, 32'd0);
        check("rr_valid", {31'd0, id_valid}, 32'd0);
        check("rr_pc",    id_pc, 32'd0);
        check("rr_inst",  id_inst, 32'd0);
        rst = 1'b1;
        stall = 1'b0;
        branch_flag = 1'b0;
        step();
        check("rr_first_pc",    id_pc, 32'h1c000000);
        check("rr_first_valid", {31'd0, id_valid}, 32'd1);
        check("rr_first_addr",  rom_inst_addr, 32'h1c000004);
        step();
        check("rr_second_pc", id_pc, 32'h1c000004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
